mem_line_arbiter: RTL and testbench

//  Shares one 256-bit line memory port between two masters: m0 = instruction-side mmu, m1 = data-side mmu.

---
 rtl/mem_line_arbiter_pkg.sv | 13 +
 rtl/mem_arb_rr2.sv | 26 ++
 rtl/mem_line_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_line_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_arbiter_pkg.sv
// rtl/mem_line_arbiter_pkg.sv - shared widths and FSM encoding for the line-memory arbiter
package mem_line_arbiter_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_LINE_W = 256;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RELEASE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// rtl/mem_arb_rr2.sv - combinational two-way round-robin pick
//
// Ports:
//   req[1:0]  request vector, bit n = master n
//   last      master granted most recently
//   grant     chosen master (valid only with valid)
//   valid     at least one request present
module mem_arb_rr2
   import mem_line_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant,
   output logic       valid
);

   always_comb begin
      valid = |req;
      // Contention goes to whoever did not win last; a lone request wins outright.
      if (req == 2'b11)
         grant = ~last;
      else
         grant = req[1];
   end

endmodule

// File: rtl/mem_line_arbiter.sv
// rtl/mem_line_arbiter.sv - round-robin arbiter sharing one 256-bit line memory port between two mmus
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the S_BUSY watchdog.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   m0_addr_i/m0_data_i      m0 line address / write data
//   m0_rd_i/m0_we_i          m0 read / write request, held until m0_ack_o
//   m0_data_o/m0_ack_o       read data (passthrough of data_i) / completion strobe
//   m1_*                     same set for m1
//   addr_o/data_o            registered slave address / write data
//   rd_o/we_o                registered slave strobes, high for the whole transaction
//   data_i/ack_i             slave read data / completion
//   bus_err_o                one-cycle pulse on watchdog abort (0 without MEM_ARB_TIMEOUT_EN)
module mem_line_arbiter
   import mem_line_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter bit FIRST_GRANT    = 1'b0
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [MEM_ADDR_W-1:0] m0_addr_i,
   input  logic [MEM_LINE_W-1:0] m0_data_i,
   input  logic                  m0_rd_i,
   input  logic                  m0_we_i,
   output logic [MEM_LINE_W-1:0] m0_data_o,
   output logic                  m0_ack_o,
   input  logic [MEM_ADDR_W-1:0] m1_addr_i,
   input  logic [MEM_LINE_W-1:0] m1_data_i,
   input  logic                  m1_rd_i,
   input  logic                  m1_we_i,
   output logic [MEM_LINE_W-1:0] m1_data_o,
   output logic                  m1_ack_o,
   output logic [MEM_ADDR_W-1:0] addr_o,
   output logic [MEM_LINE_W-1:0] data_o,
   output logic                  rd_o,
   output logic                  we_o,
   input  logic [MEM_LINE_W-1:0] data_i,
   input  logic                  ack_i,
   output logic                  bus_err_o
);

   arb_state_t state, state_nxt;
   logic       grant;
   logic       last_grant;
   logic [1:0] req;
   logic       pick;
   logic       pick_valid;
   logic       take;
   logic       done;
   logic       busy_ack;
   logic       timeout;
   logic       fwd_ack;

   assign req = {m1_rd_i | m1_we_i, m0_rd_i | m0_we_i};

   mem_arb_rr2 u_rr2 (
      .req   (req),
      .last  (last_grant),
      .grant (pick),
      .valid (pick_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      done      = 1'b0;
      busy_ack  = 1'b0;
      case (state)
         S_IDLE: begin
            if (pick_valid) begin
               take      = 1'b1;
               state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            busy_ack = ack_i;
            if (ack_i || timeout) begin
               done      = 1'b1;
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Watchdog abort also hands the owner an ack (in the release cycle) so it cannot hang.
   assign fwd_ack   = busy_ack | bus_err_o;
   assign m0_ack_o  = fwd_ack & ~grant;
   assign m1_ack_o  = fwd_ack &  grant;
   assign m0_data_o = data_i;
   assign m1_data_o = data_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_o     <= '0;
         data_o     <= '0;
         rd_o       <= 1'b0;
         we_o       <= 1'b0;
         grant      <= 1'b0;
         last_grant <= ~FIRST_GRANT;
      end else if (take) begin
         addr_o     <= pick ? m1_addr_i : m0_addr_i;
         data_o     <= pick ? m1_data_i : m0_data_i;
         // A simultaneous rd+we is treated as a write.
         we_o       <= pick ? m1_we_i : m0_we_i;
         rd_o       <= pick ? (m1_rd_i & ~m1_we_i) : (m0_rd_i & ~m0_we_i);
         grant      <= pick;
         last_grant <= pick;
      end else if (done) begin
         rd_o <= 1'b0;
         we_o <= 1'b0;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   logic [31:0] wdog;
   logic        bus_err_q;

   // ack_i in the expiry cycle wins: it is a normal completion.
   assign timeout   = (state == S_BUSY) && (wdog == 32'(TIMEOUT_CYCLES - 1)) && !ack_i;
   assign bus_err_o = bus_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog      <= '0;
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= timeout;
         if (take)
            wdog <= '0;
         else if (state == S_BUSY && !ack_i)
            wdog <= wdog + 32'd1;
      end
   end
`else
   // Parameter stays in the interface so both builds share one instantiation.
   assign timeout   = (TIMEOUT_CYCLES < 1) ? 1'b0 : 1'b0;
   assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb/tb_mem_line_arbiter.sv - randomized self-checking bench for mem_line_arbiter
module tb_mem_line_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  m0_addr_i, m1_addr_i, addr_o;
   logic [255:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o, data_o, data_i;
   logic         m0_rd_i, m0_we_i, m1_rd_i, m1_we_i;
   logic         m0_ack_o, m1_ack_o, rd_o, we_o, ack_i, bus_err_o;

   // Master-side request registers, index = master number
   logic [31:0]  ma [2];
   logic [255:0] md [2];
   logic         mr [2];
   logic         mw [2];
   bit           ack_seen [2];
   bit           abandon [2];

   // Reference model of the arbitration rules
   bit           m_last;
   int           m_owner;
   bit           m_dead;
   bit           have_exp;
   logic [31:0]  e_addr;
   logic [255:0] e_data;
   logic         e_rd, e_we;

   int           slv_wait;
   bit           slv_active;
   int           checks = 0;
   int           failures = 0;

   assign m0_addr_i = ma[0];
   assign m0_data_i = md[0];
   assign m0_rd_i   = mr[0];
   assign m0_we_i   = mw[0];
   assign m1_addr_i = ma[1];
   assign m1_data_i = md[1];
   assign m1_rd_i   = mr[1];
   assign m1_we_i   = mw[1];

   always #5 clk = ~clk;

   mem_line_arbiter #(.TIMEOUT_CYCLES(8), .FIRST_GRANT(1'b0)) dut (
      .clk(clk), .rst(rst),
      .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_rd_i(m0_rd_i), .m0_we_i(m0_we_i),
      .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
      .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_rd_i(m1_rd_i), .m1_we_i(m1_we_i),
      .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
      .addr_o(addr_o), .data_o(data_o), .rd_o(rd_o), .we_o(we_o),
      .data_i(data_i), .ack_i(ack_i), .bus_err_o(bus_err_o)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic new_req(input int k);
      int op;
      op    = $urandom_range(0, 2);
      ma[k] = $urandom();
      md[k] = rand256();
      mr[k] = (op != 1);
      mw[k] = (op != 0);
   endtask

   // Called at negedge: compare last prediction, check acks, predict the next edge.
   task automatic model_step();
      logic       busy;
      logic [1:0] req;
      int         w;
      if (have_exp) begin
         check("rd_o", rd_o, e_rd);
         check("we_o", we_o, e_we);
         check("addr_o", addr_o, e_addr);
         check("data_o", data_o, e_data);
      end
      busy = rd_o | we_o;
      req  = {mr[1] | mw[1], mr[0] | mw[0]};
      check("m0_ack", m0_ack_o, ack_i && busy && m_owner == 0);
      check("m1_ack", m1_ack_o, ack_i && busy && m_owner == 1);
      check("m0_data_o", m0_data_o, data_i);
      check("bus_err", bus_err_o, 1'b0);
      ack_seen[0] = ack_i && busy && m_owner == 0;
      ack_seen[1] = ack_i && busy && m_owner == 1;
      if (busy) begin
         if (ack_i) begin
            e_rd = 1'b0;
            e_we = 1'b0;
         end
         m_dead = ack_i;
      end else if (m_dead) begin
         m_dead = 1'b0;
      end else if (req != 2'b00) begin
         w       = (req == 2'b11) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
         e_addr  = ma[w];
         e_data  = md[w];
         e_we    = mw[w];
         e_rd    = mr[w] & ~mw[w];
         m_last  = (w == 1);
         m_owner = w;
      end
      have_exp = 1'b1;
   endtask

   // Called just after posedge: slave and master behaviour for the coming cycle.
   task automatic drive_step(input bit allow_new);
      logic busy;
      busy = rd_o | we_o;
      if (busy) begin
         if (!slv_active) begin
            slv_active = 1'b1;
            slv_wait   = $urandom_range(0, 4);
         end
         if (slv_wait == 0) begin
            ack_i      = 1'b1;
            slv_active = 1'b0;
         end else begin
            ack_i = 1'b0;
            slv_wait--;
         end
      end else begin
         slv_active = 1'b0;
         ack_i      = ($urandom_range(0, 7) == 0);
      end
      data_i = rand256();
      for (int k = 0; k < 2; k++) begin
         if (ack_seen[k]) begin
            mr[k] = 1'b0;
            mw[k] = 1'b0;
            ack_seen[k] = 1'b0;
            abandon[k]  = 1'b0;
         end else if (busy && m_owner == k && !abandon[k] && $urandom_range(0, 15) == 0) begin
            mr[k] = 1'b0;
            mw[k] = 1'b0;
            abandon[k] = 1'b1;
         end else if (!(mr[k] | mw[k]) && !abandon[k] && allow_new && $urandom_range(0, 1) == 1) begin
            new_req(k);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         ma[k] = '0; md[k] = '0; mr[k] = 1'b0; mw[k] = 1'b0;
         ack_seen[k] = 1'b0; abandon[k] = 1'b0;
      end
      ack_i = 1'b0;
      data_i = '0;
      slv_active = 1'b0;
      slv_wait = 0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_addr", addr_o, 32'h0);
      check("rst_data", data_o, 256'h0);
      check("rst_rd", rd_o, 1'b0);
      check("rst_we", we_o, 1'b0);
      check("rst_ack0", m0_ack_o, 1'b0);
      check("rst_ack1", m1_ack_o, 1'b0);
      check("rst_err", bus_err_o, 1'b0);
      rst = 1'b1;

      // Reset in the middle of a read, then a late slave ack
      @(posedge clk); #1;
      ma[0] = 32'h0000_1000; mr[0] = 1'b1;
      @(posedge clk); #1;
      check("lat_rd", rd_o, 1'b1);
      check("lat_addr", addr_o, 32'h0000_1000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("async_rd", rd_o, 1'b0);
      check("async_addr", addr_o, 32'h0);
      mr[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      ack_i = 1'b1;
      #1;
      check("late_ack0", m0_ack_o, 1'b0);
      check("late_ack1", m1_ack_o, 1'b0);
      @(posedge clk); #1;
      ack_i = 1'b0;
      check("late_idle", rd_o | we_o, 1'b0);

      // Random phase, starting with contention: m0 read, m1 rd+we of A5 pattern
      m_last = 1'b1; m_owner = 0; m_dead = 1'b0; have_exp = 1'b0;
      ma[0] = 32'h0000_1000; md[0] = rand256(); mr[0] = 1'b1; mw[0] = 1'b0;
      ma[1] = 32'h0001_0020; md[1] = {32{8'hA5}}; mr[1] = 1'b1; mw[1] = 1'b1;
      repeat (3000) begin
         @(negedge clk); model_step();
         @(posedge clk); #1; drive_step(1'b1);
      end
      repeat (40) begin
         @(negedge clk); model_step();
         @(posedge clk); #1; drive_step(1'b0);
      end
      ack_i = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
      for (int v = 0; v < 2; v++) begin
         bit seen;
         seen = 1'b0;
         @(posedge clk); #1;
         ma[0] = 32'h0000_1000; mr[0] = 1'b1; mw[0] = 1'b0;
         for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = rd_o;
         end
         check("to_rise", seen, 1'b1);
         // Cycle 1 is the first cycle with rd_o high.
         for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            if (v == 0) begin
               check("to_err", bus_err_o, c == 9);
               check("to_ack0", m0_ack_o, c == 9);
            end else begin
               check("to_err_v", bus_err_o, 1'b0);
               check("to_ack0_v", m0_ack_o, c == 8);
            end
            @(posedge clk); #1;
            ack_i = (v == 1) && (c + 1 == 8);
            if (c == 9) mr[0] = 1'b0;
         end
         @(negedge clk);
         check("to_rd_off", rd_o, 1'b0);
         check("to_ack1", m1_ack_o, 1'b0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
